// File: rtl/add_sub_seq_ctrl_if.sv
// Request/result bundle for add_sub_seq_ctrl. The overflow_out signal exists only when
// OVERFLOW_FLAG_EN is defined.
interface add_sub_seq_ctrl_if #(
  parameter int unsigned W = 16
);
  logic         in_valid_in;
  logic         in_ready_out;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         control_in;
  logic         out_valid_out;
  logic         out_ready_in;
  logic [W-1:0] result_out;
  logic         carry_out;
  logic         busy_out;
`ifdef OVERFLOW_FLAG_EN
  logic         overflow_out;

  modport master (
    output in_valid_in, a_in, b_in, control_in, out_ready_in,
    input  in_ready_out, out_valid_out, result_out, carry_out, busy_out, overflow_out
  );
  modport slave (
    input  in_valid_in, a_in, b_in, control_in, out_ready_in,
    output in_ready_out, out_valid_out, result_out, carry_out, busy_out, overflow_out
  );
`else
  modport master (
    output in_valid_in, a_in, b_in, control_in, out_ready_in,
    input  in_ready_out, out_valid_out, result_out, carry_out, busy_out
  );
  modport slave (
    input  in_valid_in, a_in, b_in, control_in, out_ready_in,
    output in_ready_out, out_valid_out, result_out, carry_out, busy_out
  );
`endif
endinterface

// File: rtl/add_sub_seq_ctrl.sv
// Wide add/sub built from one DATA_SIZE-bit slice reused over NUM_WORDS cycles, LSW first.
// Optional OVERFLOW_FLAG_EN adds a signed-overflow flag held with the result.
module add_sub_seq_ctrl #(
  parameter int unsigned DATA_SIZE = 4,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input logic            clk_in,
  input logic            rst_in,
  add_sub_seq_ctrl_if.slave bus
);
  localparam int unsigned W = DATA_SIZE * NUM_WORDS;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic                 ctrl_q, ctrl_d;
  logic                 carry_q, carry_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [W-1:0]         result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 valid_q, valid_d;

  logic [DATA_SIZE-1:0] a_sl, b_sl, b_eff;
  logic [DATA_SIZE:0]   sum;
  logic                 last;

  // Word-select muxes instead of a variable part-select keep index widths explicit.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sl = a_q[i*DATA_SIZE +: DATA_SIZE];
        b_sl = b_q[i*DATA_SIZE +: DATA_SIZE];
      end
    end
    b_eff = ctrl_q ? ~b_sl : b_sl;
    sum   = {1'b0, a_sl} + {1'b0, b_eff} + {{DATA_SIZE{1'b0}}, carry_q};
    last  = (idx_q == IDX_W'(NUM_WORDS - 1));
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  logic cin_msb;
  // Carry into the slice MSB recovered from its sum bit.
  assign cin_msb = a_sl[DATA_SIZE-1] ^ b_eff[DATA_SIZE-1] ^ sum[DATA_SIZE-1];
  assign bus.overflow_out = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    valid_d  = valid_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid_in) begin
          a_d      = bus.a_in;
          b_d      = bus.b_in;
          ctrl_d   = bus.control_in;
          carry_d  = bus.control_in;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
          if (idx_q == IDX_W'(i)) result_d[i*DATA_SIZE +: DATA_SIZE] = sum[DATA_SIZE-1:0];
        end
        carry_d = sum[DATA_SIZE];
        idx_d   = idx_q + IDX_W'(1);
        if (last) begin
          cout_d  = sum[DATA_SIZE];
          valid_d = 1'b1;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = cin_msb ^ sum[DATA_SIZE];
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready_in) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      valid_q  <= valid_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready_out  = (state_q == StIdle);
  assign bus.busy_out      = (state_q != StIdle);
  assign bus.out_valid_out = valid_q;
  assign bus.result_out    = result_q;
  assign bus.carry_out     = cout_q;

endmodule
